bcd_display_ctrl: RTL and testbench

- Sequences binary-to-BCD conversion of a 16-bit value for a 4-digit decimal display.
- Accepts a value over a valid/ready handshake and runs a serial shift-add-3 (double dabble) conversion over 16 cycles.
- Values above 9999 saturate to 9999 without running the conversion.
- Holds the digits in registers and time-multiplexes them onto a common seven-segment bus with leading-zero blanking.

---
 rtl/bcd_disp_pkg.sv | 47 ++++
 rtl/bcd_display_ctrl_scanner.sv | 63 ++++++
 rtl/bcd_display_ctrl.sv | 137 +++++++++++++
 tb/tb_bcd_display_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared types, constants and helpers for the BCD display controller.
// Covers the FSM encoding, saturation limit, blank pattern, glyph decode and the add-3 step.
package bcd_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_STORE = 2'd2
    } state_e;

    localparam int          NUM_DIGITS = 4;
    localparam logic [15:0] SAT_MAX    = 16'd9999;
    localparam logic [6:0]  SEG_BLANK  = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; codes 10-15 cannot occur and show blank
    function automatic logic [6:0] seg7_glyph(input logic [3:0] nibble);
        logic [6:0] g;
        case (nibble)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    // Double-dabble correction: add 3 to every nibble that is 5 or more
    function automatic logic [15:0] bcd_adjust(input logic [15:0] bcd);
        logic [15:0] r;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_display_ctrl_scanner.sv
// Free-running digit scanner: rotates the active-low anode enable across four digits
// and drives the shared segment bus, blanking leading zeros when enabled.
module digit_scanner
    import bcd_disp_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter bit BLANK_LEAD = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic [3:0] thousands,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt_r;
    logic [1:0]    idx_r;
    logic          wrap_s;
    logic [1:0]    idx_s;
    logic [3:0]    blank_s;
    logic [3:0]    digit_s [NUM_DIGITS];
    logic [6:0]    seg_s;

    // Wrap detect, next index, leading-zero blanking and glyph select
    always_comb begin
        wrap_s     = (cnt_r == CW'(SCAN_DIV - 1));
        idx_s      = wrap_s ? (idx_r + 2'd1) : idx_r;
        digit_s[0] = ones;
        digit_s[1] = tens;
        digit_s[2] = hundreds;
        digit_s[3] = thousands;
        blank_s[3] = BLANK_LEAD && (thousands == 4'd0);
        blank_s[2] = blank_s[3] && (hundreds == 4'd0);
        blank_s[1] = blank_s[2] && (tens == 4'd0);
        blank_s[0] = 1'b0;
        if (blank_s[idx_s]) begin
            seg_s = SEG_BLANK;
        end else begin
            seg_s = seg7_glyph(digit_s[idx_s]);
        end
    end

    // Scan counter, index and registered anode/segment outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            idx_r <= 2'd0;
            an    <= 4'b1110;
            seg   <= 7'b1000000;
        end else begin
            cnt_r <= wrap_s ? '0 : (cnt_r + CW'(1));
            idx_r <= idx_s;
            an    <= ~(4'b0001 << idx_s);
            seg   <= seg_s;
        end
    end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Binary-to-BCD display controller: handshake intake, serial double-dabble conversion
// with saturation at 9999, registered digit outputs and a multiplexed seven-segment drive.
module bcd_display_ctrl
    import bcd_disp_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter bit BLANK_LEAD = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_value,
    output logic        done,
    output logic        saturated,
    output logic [3:0]  ones,
    output logic [3:0]  tens,
    output logic [3:0]  hundreds,
    output logic [3:0]  thousands,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    state_e      state_r;
    state_e      state_s;
    logic [15:0] bin_r;
    logic [15:0] bcd_r;
    logic [15:0] bcd_adj_s;
    logic [3:0]  iter_r;
    logic        sat_r;
    logic        over_s;

    // Next-state decode; accept only happens in IDLE
    always_comb begin
        state_s   = state_r;
        over_s    = (in_value > SAT_MAX);
        bcd_adj_s = bcd_adjust(bcd_r);
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_s = over_s ? ST_STORE : ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (iter_r == 4'd15) begin
                    state_s = ST_STORE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_STORE: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register with registered ready (high whenever the next state is IDLE)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            in_ready <= 1'b1;
        end else begin
            state_r  <= state_s;
            in_ready <= (state_s == ST_IDLE);
        end
    end

    // Conversion datapath; bcd_r doubles as the staging register for STORE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_r  <= 16'd0;
            bcd_r  <= 16'd0;
            iter_r <= 4'd0;
            sat_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && over_s) begin
                        bcd_r <= 16'h9999;
                        sat_r <= 1'b1;
                    end else if (in_valid) begin
                        bin_r  <= in_value;
                        bcd_r  <= 16'd0;
                        iter_r <= 4'd0;
                        sat_r  <= 1'b0;
                    end else begin
                        sat_r <= sat_r;
                    end
                end
                ST_SHIFT: begin
                    {bcd_r, bin_r} <= {bcd_adj_s[14:0], bin_r, 1'b0};
                    iter_r         <= iter_r + 4'd1;
                end
                default: begin
                    sat_r <= sat_r;
                end
            endcase
        end
    end

    // Output digits and status change only on the STORE edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones      <= 4'd0;
            tens      <= 4'd0;
            hundreds  <= 4'd0;
            thousands <= 4'd0;
            saturated <= 1'b0;
            done      <= 1'b0;
        end else if (state_r == ST_STORE) begin
            ones      <= bcd_r[3:0];
            tens      <= bcd_r[7:4];
            hundreds  <= bcd_r[11:8];
            thousands <= bcd_r[15:12];
            saturated <= sat_r;
            done      <= 1'b1;
        end else begin
            done      <= 1'b0;
        end
    end

    digit_scanner #(
        .SCAN_DIV   (SCAN_DIV),
        .BLANK_LEAD (BLANK_LEAD)
    ) u_scanner (
        .clk       (clk),
        .rst_n     (rst_n),
        .ones      (ones),
        .tens      (tens),
        .hundreds  (hundreds),
        .thousands (thousands),
        .an        (an),
        .seg       (seg)
    );

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Scoreboard bench for bcd_display_ctrl: directed values with hand-computed digits,
// plus scan/blanking checks on two parameterisations sharing the same stimulus.
module tb_bcd_display_ctrl;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] GB = 7'h7F;

    typedef struct {
        logic [15:0] digits;
        logic        sat;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_value;
    logic        in_ready, done, saturated;
    logic [3:0]  ones, tens, hundreds, thousands, an;
    logic [6:0]  seg;
    logic        in_ready2, done2, saturated2;
    logic [3:0]  ones2, tens2, hundreds2, thousands2, an2;
    logic [6:0]  seg2;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t e;

    bcd_display_ctrl #(.SCAN_DIV(4), .BLANK_LEAD(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .done(done), .saturated(saturated), .ones(ones),
        .tens(tens), .hundreds(hundreds), .thousands(thousands), .an(an), .seg(seg)
    );

    bcd_display_ctrl #(.SCAN_DIV(2), .BLANK_LEAD(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_value(in_value), .done(done2), .saturated(saturated2), .ones(ones2),
        .tens(tens2), .hundreds(hundreds2), .thousands(thousands2), .an(an2), .seg(seg2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pops one expectation; between accept and done the block must be busy
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'(0));
                end else begin
                    e = sb.pop_front();
                    chk("digits", 32'({thousands, hundreds, tens, ones}), 32'(e.digits));
                    chk("saturated", 32'(saturated), 32'(e.sat));
                    chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    chk("in_ready_at_done", 32'(in_ready), 32'(1));
                end
            end else if (sb.size() > 0) begin
                chk("in_ready_busy", 32'(in_ready), 32'(0));
            end
        end
    end

    task automatic send(input logic [15:0] v, input logic [15:0] exp_digits,
                        input logic exp_sat, input bit hold_alt);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_value = v;
        for (int i = 0; i < 60; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            in_value = v;
        end
        if (!ok) begin
            chk("accept_timeout", 32'(0), 32'(1));
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            sb.push_back('{exp_digits, exp_sat, cyc, exp_sat ? 1 : 17});
            if (hold_alt) begin
                for (int k = 0; k < 15; k++) begin
                    @(negedge clk);
                    in_value = k[0] ? 16'd1111 : 16'd8888;
                end
                @(negedge clk);
            end
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 32'(sb.size()), 32'(0));
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic scan_check(input bit which, input logic [6:0] g0, input logic [6:0] g1,
                              input logic [6:0] g2, input logic [6:0] g3,
                              input int div, input int ncyc);
        logic [3:0] a, prev;
        logic [6:0] s;
        int run;
        bit seen;
        prev = 4'hE;
        run = 0;
        seen = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            a = which ? an2 : an;
            s = which ? seg2 : seg;
            case (a)
                4'b1110: chk("seg_idx0", 32'(s), 32'(g0));
                4'b1101: chk("seg_idx1", 32'(s), 32'(g1));
                4'b1011: chk("seg_idx2", 32'(s), 32'(g2));
                4'b0111: chk("seg_idx3", 32'(s), 32'(g3));
                default: chk("an_onehot", 32'(a), 32'(4'b1110));
            endcase
            if (i > 0 && a != prev) begin
                chk("an_rotate", 32'(a), 32'({prev[2:0], prev[3]}));
                if (seen) chk("an_dwell", 32'(run), 32'(div));
                seen = 1'b1;
                run = 1;
            end else begin
                run++;
            end
            prev = a;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_value = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_saturated", 32'(saturated), 32'(0));
        chk("rst_digits", 32'({thousands, hundreds, tens, ones}), 32'(0));
        chk("rst_an", 32'(an), 32'(4'b1110));
        chk("rst_seg", 32'(seg), 32'(G0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send(16'd4321, 16'h4321, 1'b0, 1'b0);
        wait_idle();

        send(16'd9999, 16'h9999, 1'b0, 1'b0);
        send(16'd10000, 16'h9999, 1'b1, 1'b0);
        send(16'd65535, 16'h9999, 1'b1, 1'b0);
        wait_idle();

        send(16'd2468, 16'h2468, 1'b0, 1'b1);
        wait_idle();

        send(16'd7, 16'h0007, 1'b0, 1'b0);
        wait_idle();
        scan_check(1'b0, G7, GB, GB, GB, 4, 40);

        send(16'd0, 16'h0000, 1'b0, 1'b0);
        wait_idle();
        scan_check(1'b1, G0, G0, G0, G0, 2, 20);

        send(16'd1005, 16'h1005, 1'b0, 1'b0);
        wait_idle();
        scan_check(1'b0, G5, G0, G0, G1, 4, 40);

        // Reset in the middle of a conversion discards it
        send(16'd1234, 16'h1234, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'(1));
        chk("post_rst_digits", 32'({thousands, hundreds, tens, ones}), 32'(0));
        chk("post_rst_done", 32'(done), 32'(0));
        chk("post_rst_an", 32'(an), 32'(4'b1110));
        repeat (25) @(negedge clk);
        chk("post_rst_digits_hold", 32'({thousands, hundreds, tens, ones}), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
